// File: rtl/chroni_text_fetch_pkg.sv
// Shared types, defaults and helpers for the chroni text-mode character fetcher.
package chroni_text_fetch_pkg;
    localparam int COLS_DEF    = 100;
    localparam int ROWS_DEF    = 75;
    localparam int FONT_H_DEF  = 8;
    localparam int VRAM_AW_DEF = 13;
    localparam int FETCH_LEAD  = 8;
    localparam int FONT_AW     = 11;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_FETCH = 1'b1
    } fetch_state_e;

    function automatic logic [FONT_AW-1:0] font_addr_pack(input logic [7:0] code,
                                                           input logic [2:0] row);
        return {code, row};
    endfunction
endpackage

// File: rtl/chroni_text_fetch_if.sv
// Memory-side and serializer-side bus of the text fetcher.
interface chroni_text_fetch_if #(
    parameter int VRAM_AW = 13
);
    logic               vram_rd;
    logic [VRAM_AW-1:0] vram_addr;
    logic [15:0]        vram_data;
    logic               font_rd;
    logic [10:0]        font_addr;
    logic [7:0]         font_data;
    logic [7:0]         pix_pattern;
    logic [7:0]         pix_attr;
    logic               pix_load;

    modport master (
        output vram_rd, vram_addr, font_rd, font_addr, pix_pattern, pix_attr, pix_load,
        input  vram_data, font_data
    );

    modport slave (
        input  vram_rd, vram_addr, font_rd, font_addr, pix_pattern, pix_attr, pix_load,
        output vram_data, font_data
    );
endinterface

// File: rtl/chroni_text_fetch_row_ctr.sv
// Tracks glyph scanline, text row and VRAM row base across completed lines.
module chroni_text_fetch_row_ctr
    import chroni_text_fetch_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int FONT_H    = FONT_H_DEF,
    parameter int VRAM_BASE = 0,
    parameter int VRAM_AW   = VRAM_AW_DEF
) (
    input  logic               vga_clk,
    input  logic               reset_n,
    input  logic               frame_start,
    input  logic               line_done,
    output logic [2:0]         font_row,
    output logic [VRAM_AW-1:0] row_base,
    output logic               overscan
);
    localparam int CRW = $clog2(ROWS + 1);

    logic [CRW-1:0] char_row;

    always_ff @(posedge vga_clk) begin
        if (!reset_n || frame_start) begin
            font_row <= '0;
            row_base <= VRAM_AW'(VRAM_BASE);
            char_row <= '0;
        end else if (line_done && !overscan) begin
            if (font_row == 3'(FONT_H - 1)) begin
                font_row <= '0;
                row_base <= row_base + VRAM_AW'(COLS);
                char_row <= char_row + 1'b1;
            end else begin
                font_row <= font_row + 3'd1;
            end
        end
    end

    // Past the last text row everything freezes until the next frame.
    assign overscan = (char_row == CRW'(ROWS));
endmodule

// File: rtl/chroni_text_fetch.sv
// Per-scanline character/font fetcher: one 8-cycle slot sequence per text cell.
module chroni_text_fetch
    import chroni_text_fetch_pkg::*;
#(
    parameter int COLS      = COLS_DEF,
    parameter int ROWS      = ROWS_DEF,
    parameter int FONT_H    = FONT_H_DEF,
    parameter int VRAM_BASE = 0,
    parameter int VRAM_AW   = VRAM_AW_DEF
) (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic frame_start,
    input  logic line_start,
    input  logic line_active,
    output logic busy,
    chroni_text_fetch_if.master bus
);
    localparam int CW = $clog2(COLS);

    fetch_state_e       state, state_nxt;
    logic [2:0]         slot;
    logic [CW-1:0]      col;
    logic [VRAM_AW-1:0] addr_q;
    logic [10:0]        font_addr_q, font_addr_c;
    logic [7:0]         attr_lat, staging, pat_q, attr_q;
    logic [2:0]         font_row;
    logic [VRAM_AW-1:0] row_base;
    logic               overscan;
    logic               fetching, start, last_cell, line_done, font_rd_c;

    assign fetching  = (state == ST_FETCH);
    assign start     = line_start && line_active;
    assign last_cell = fetching && (slot == 3'd7) && (col == CW'(COLS - 1));
    // A line interrupted by a new line_start or frame_start never counts as done.
    assign line_done = last_cell && !frame_start && !line_start;

    chroni_text_fetch_row_ctr #(
        .COLS(COLS), .ROWS(ROWS), .FONT_H(FONT_H), .VRAM_BASE(VRAM_BASE), .VRAM_AW(VRAM_AW)
    ) u_row_ctr (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
        .line_done(line_done), .font_row(font_row), .row_base(row_base), .overscan(overscan)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_FETCH;
            ST_FETCH: begin
                if (start)                                         state_nxt = ST_FETCH;
                else if (frame_start || line_start || last_cell)   state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            slot        <= '0;
            col         <= '0;
            addr_q      <= '0;
            font_addr_q <= '0;
            attr_lat    <= '0;
            staging     <= '0;
            pat_q       <= '0;
            attr_q      <= '0;
        end else begin
            state       <= state_nxt;
            font_addr_q <= font_addr_c;
            if (start) begin
                slot <= '0;
                col  <= '0;
                // frame_start in the same cycle resets the rows, so begin at row 0.
                if (frame_start)    addr_q <= VRAM_AW'(VRAM_BASE);
                else if (!overscan) addr_q <= row_base;
            end else if (fetching) begin
                slot <= slot + 3'd1;
                if (slot == 3'd7) begin
                    col <= col + 1'b1;
                    if (!last_cell && !overscan) addr_q <= addr_q + 1'b1;
                end
            end
            if (fetching && slot == 3'd1) attr_lat <= bus.vram_data[15:8];
            if (fetching && slot == 3'd2) staging  <= bus.font_data;
            if (fetching && slot == 3'd6) begin
                pat_q  <= overscan ? 8'h00 : staging;
                attr_q <= overscan ? 8'h00 : attr_lat;
            end
        end
    end

    assign font_rd_c   = fetching && (slot == 3'd1) && !overscan;
    assign font_addr_c = font_rd_c ? font_addr_pack(bus.vram_data[7:0], font_row) : font_addr_q;

    assign bus.vram_rd     = fetching && (slot == 3'd0) && !overscan;
    assign bus.vram_addr   = addr_q;
    assign bus.font_rd     = font_rd_c;
    assign bus.font_addr   = font_addr_c;
    assign bus.pix_pattern = pat_q;
    assign bus.pix_attr    = attr_q;
    assign bus.pix_load    = fetching && (slot == 3'd7);
    assign busy            = fetching;
endmodule

// File: tb/tb_chroni_text_fetch.sv
// Randomized bench for chroni_text_fetch against a cycle-offset reference model.
module tb_chroni_text_fetch;
    localparam int COLS      = 10;
    localparam int ROWS      = 4;
    localparam int FONT_H    = 4;
    localparam int VRAM_BASE = 8185;
    localparam int VRAM_AW   = 13;
    localparam int VDEPTH    = 1 << VRAM_AW;
    localparam int LINE      = 8 * COLS;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_start = 1'b0, line_start = 1'b0, line_active = 1'b0;
    logic busy;

    chroni_text_fetch_if #(.VRAM_AW(VRAM_AW)) bus ();

    chroni_text_fetch #(
        .COLS(COLS), .ROWS(ROWS), .FONT_H(FONT_H), .VRAM_BASE(VRAM_BASE), .VRAM_AW(VRAM_AW)
    ) dut (
        .vga_clk(vga_clk), .reset_n(reset_n), .frame_start(frame_start),
        .line_start(line_start), .line_active(line_active), .busy(busy), .bus(bus)
    );

    always #12 vga_clk = ~vga_clk;

    logic [15:0] vram [0:VDEPTH-1];
    logic [7:0]  font [0:2047];

    always @(posedge vga_clk) begin
        if (bus.vram_rd) bus.vram_data <= vram[bus.vram_addr];
        if (bus.font_rd) bus.font_data <= font[bus.font_addr];
    end

    int checks = 0, failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    int n_vrd = 0, n_frd = 0, n_pix = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    always @(posedge vga_clk) cyc <= cyc + 1;

    // Reference model: a line is described only by its start cycle, the row it
    // reads and whether it is in overscan; every output follows from the offset.
    bit m_act = 1'b0, m_ovs = 1'b0;
    int m_t0 = 0, m_base = 0, m_fr = 0, m_cr = 0, m_lfr = 0;

    always @(negedge vga_clk) begin
        int d, k, a;
        bit eb, ev, ef, ep;
        logic [15:0] w;
        logic [7:0]  g;
        if (cmp_en) begin
            d  = cyc - m_t0;
            eb = m_act && d >= 1 && d <= LINE;
            ev = eb && ((d - 1) % 8 == 0) && !m_ovs;
            ef = eb && ((d - 1) % 8 == 1) && !m_ovs;
            ep = eb && (d % 8 == 0);
            k  = (d - 1) / 8;
            a  = (m_base + k) % VDEPTH;
            w  = vram[a];
            chk("strobes", 32'({busy, bus.vram_rd, bus.font_rd, bus.pix_load}), 32'({eb, ev, ef, ep}));
            if (ev) chk("vram_addr", 32'(bus.vram_addr), 32'(a));
            if (ef) chk("font_addr", 32'(bus.font_addr), 32'({w[7:0], 3'(m_lfr)}));
            if (ep) begin
                a = (m_base + d / 8 - 1) % VDEPTH;
                w = vram[a];
                g = font[{w[7:0], 3'(m_lfr)}];
                chk("pix_pattern", 32'(bus.pix_pattern), m_ovs ? 32'd0 : 32'(g));
                chk("pix_attr",    32'(bus.pix_attr),    m_ovs ? 32'd0 : 32'(w[15:8]));
            end
            n_vrd += int'(bus.vram_rd);
            n_frd += int'(bus.font_rd);
            n_pix += int'(bus.pix_load);

            if (!reset_n) begin
                m_act = 1'b0; m_fr = 0; m_cr = 0;
            end else begin
                if (m_act && d == LINE && !frame_start && !line_start) begin
                    m_act = 1'b0;
                    if (!m_ovs) begin
                        m_fr++;
                        if (m_fr == FONT_H) begin m_fr = 0; m_cr++; end
                    end
                end
                if (frame_start) begin m_fr = 0; m_cr = 0; m_act = 1'b0; end
                if (line_start) begin
                    if (line_active) begin
                        m_act = 1'b1; m_t0 = cyc; m_lfr = m_fr;
                        m_ovs = (m_cr == ROWS); m_base = VRAM_BASE + m_cr * COLS;
                    end else begin
                        m_act = 1'b0;
                    end
                end
            end
        end
    end

    task automatic pulse(input bit fs, input bit ls, input bit la);
        frame_start = fs; line_start = ls; line_active = la;
        @(posedge vga_clk); #1;
        frame_start = 1'b0; line_start = 1'b0; line_active = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge vga_clk);
        #1;
    endtask

    task automatic run_line(input bit la, output int dv, output int df, output int dp);
        int v0, f0, p0;
        v0 = n_vrd; f0 = n_frd; p0 = n_pix;
        pulse(1'b0, 1'b1, la);
        idle(LINE + 3);
        dv = n_vrd - v0; df = n_frd - f0; dp = n_pix - p0;
    endtask

    initial begin
        int dv, df, dp, v0, r;
        for (int i = 0; i < VDEPTH; i++) vram[i] = 16'($urandom);
        for (int i = 0; i < 2048; i++)   font[i] = 8'($urandom);
        vram[VRAM_BASE]  = 16'h0241;
        font[11'h208]    = 8'hA5;
        vram[(VRAM_BASE + COLS) % VDEPTH] = 16'h1733;
        font[{8'h33, 3'd0}] = 8'h3C;

        idle(3);
        cmp_en = 1'b1;
        reset_n = 1'b1;
        idle(2);

        // First line of a frame: literal timing and data.
        pulse(1'b1, 1'b0, 1'b0);
        idle(2);
        v0 = n_pix;
        pulse(1'b0, 1'b1, 1'b1);
        @(negedge vga_clk);
        chk("t1_vram_rd",   32'(bus.vram_rd), 32'd1);
        chk("t1_vram_addr", 32'(bus.vram_addr), 32'(VRAM_BASE));
        @(negedge vga_clk);
        chk("t2_font_addr", 32'(bus.font_addr), 32'h208);
        repeat (6) @(negedge vga_clk);
        chk("t8_pix", 32'({bus.pix_load, bus.pix_pattern, bus.pix_attr}), 32'h1A502);
        repeat (LINE - 15) @(negedge vga_clk);
        chk("last_vram_addr", 32'(bus.vram_addr), 32'((VRAM_BASE + COLS - 1) % VDEPTH));
        repeat (8) @(negedge vga_clk);
        chk("busy_end", 32'(busy), 32'd0);
        @(posedge vga_clk); #1;
        chk("pix_count", 32'(n_pix - v0), 32'(COLS));

        // Second line uses glyph scanline 1.
        pulse(1'b0, 1'b1, 1'b1);
        @(negedge vga_clk);
        @(negedge vga_clk);
        chk("line2_font_row", 32'(bus.font_addr[2:0]), 32'd1);
        idle(LINE);

        // Inactive line_start does nothing.
        run_line(1'b0, dv, df, dp);
        chk("inactive_counts", 32'({8'(dv), 8'(df), 8'(dp)}), 32'd0);

        // Finish text row 0, first line of row 1 wraps through the top of VRAM.
        for (int i = 2; i < FONT_H; i++) run_line(1'b1, dv, df, dp);
        pulse(1'b0, 1'b1, 1'b1);
        @(negedge vga_clk);
        chk("row1_addr", 32'(bus.vram_addr), 32'((VRAM_BASE + COLS) % VDEPTH));
        @(negedge vga_clk);
        chk("row1_font_addr", 32'(bus.font_addr), 32'({8'h33, 3'd0}));
        idle(LINE);

        // Reset mid-fetch.
        pulse(1'b0, 1'b1, 1'b1);
        idle(20);
        reset_n = 1'b0;
        idle(1);
        @(negedge vga_clk);
        chk("rst_strb", 32'({busy, bus.vram_rd, bus.font_rd, bus.pix_load}), 32'd0);
        chk("rst_pix",  32'({bus.pix_pattern, bus.pix_attr}), 32'd0);
        chk("rst_addr", 32'({bus.vram_addr, bus.font_addr}), 32'd0);
        idle(2);
        reset_n = 1'b1;
        v0 = n_vrd + n_frd + n_pix;
        idle(20);
        chk("post_rst_quiet", 32'(n_vrd + n_frd + n_pix - v0), 32'd0);

        // frame_start aborts a line at column 5; next line reads row 0 again.
        run_line(1'b1, dv, df, dp);
        pulse(1'b0, 1'b1, 1'b1);
        idle(8 * 5);
        pulse(1'b1, 1'b0, 1'b0);
        v0 = n_vrd + n_frd + n_pix;
        @(negedge vga_clk);
        chk("abort_busy", 32'(busy), 32'd0);
        idle(10);
        chk("abort_quiet", 32'(n_vrd + n_frd + n_pix - v0), 32'd0);
        pulse(1'b0, 1'b1, 1'b1);
        @(negedge vga_clk);
        chk("abort_restart_addr", 32'(bus.vram_addr), 32'(VRAM_BASE));
        idle(LINE);

        // Overscan after ROWS*FONT_H lines.
        pulse(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < ROWS * FONT_H; i++) run_line(1'b1, dv, df, dp);
        run_line(1'b1, dv, df, dp);
        chk("ovs_counts", 32'({8'(dv), 8'(df), 8'(dp)}), 32'(COLS));

        // Random mix of lines, restarts, frames and coincident events.
        for (int it = 0; it < 80; it++) begin
            r = $urandom_range(0, 9);
            case (r)
                0: begin pulse(1'b1, 1'b0, 1'b0); idle($urandom_range(0, 5)); end
                1: begin pulse(1'b0, 1'b1, 1'b0); idle($urandom_range(0, 5)); end
                2: begin pulse(1'b0, 1'b1, 1'b1); idle($urandom_range(0, LINE - 2)); end
                3: begin pulse(1'b1, 1'b1, 1'b1); idle(LINE + $urandom_range(1, 6)); end
                default: begin pulse(1'b0, 1'b1, 1'b1); idle(LINE + $urandom_range(0, 6)); end
            endcase
        end
        idle(LINE + 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
